watch_set_ctrl: RTL and testbench
=================================

# watch_set_ctrl

Button-driven time-setting controller sitting directly upstream of the watch date/time counter. It snapshots the running time, lets the user step through and edit year, month, day, hour, minute and second with up/down buttons, then issues a one-cycle load strobe with the packed time word. While idle it never drives the load strobe, so the counter free-runs.

## Interface
- HOLD_CYC, 32'd50_000_000: cycles a button must be held before auto-repeat starts (used only with the auto-repeat macro).
- RPT_CYC, 32'd10_000_000: cycles between auto-repeat steps.
- TIMEOUT_CYC, 32'd500_000_000: idle cycles in an edit state before edit is abandoned. 0 disables the timeout.

- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- cur_time  in  48  running time {year, month, day, hour, minute, second}, 8 bits each
- btn_mode  in  1  synchronised level; rising edge enters edit mode or advances to the next field
- btn_up  in  1  synchronised level; rising edge increments the current field
- btn_down  in  1  synchronised level; rising edge decrements the current field
- btn_cancel  in  1  synchronised level; rising edge abandons the edit
- set_time  out  1  one-cycle load strobe to the counter
- bin_time  out  48  edit buffer, packed like cur_time; valid when set_time=1
- editing  out  1  1 in any edit state
- field_sel  out  3  0=none, 1=year, 2=month, 3=day, 4=hour, 5=minute, 6=second (for display blink)

## Operation
- Rising edges are detected on each button with one previous-value register per button. A press is the cycle where the level is 1 and the previous value was 0.
- States: IDLE, E_YEAR, E_MON, E_DAY, E_HOUR, E_MIN, E_SEC, COMMIT.
- IDLE:
  - A mode press copies cur_time into the buffer and moves to E_YEAR.
  - Up, down and cancel presses are ignored.
- E_x: a mode press moves to the next field. E_SEC plus a mode press moves to COMMIT.
- COMMIT lasts one cycle: set_time=1, bin_time=buffer, then IDLE.
- Priority within a cycle: cancel > mode > up/down.
  - Cancel in any edit state returns to IDLE with no set_time.
  - If up and down are pressed in the same cycle, both are ignored.
- Field ranges. Increment past the maximum wraps to the minimum; decrement past the minimum wraps to the maximum.
  - year 0–255
  - month 1–12
  - hour 0–23
  - minute and second 0–59
  - day 1–max_day(month): 31 for months 1,3,5,7,8,10,12; 30 for months 4,6,9,11; 28 for February. There are no leap years.
- Whenever the month changes, if day > max_day(new month), day is clamped to max_day in the same cycle.
- Out-of-range snapshot values (e.g. month=0) are normalised to the field minimum on the first up/down step of that field. Other fields keep their snapshot value.
- Timeout: a counter is cleared on any button press and counts every cycle in an edit state. Reaching TIMEOUT_CYC returns the block to IDLE without set_time.

## Timing
- Reset values: state IDLE, set_time=0, bin_time=0, editing=0, field_sel=0, all edge registers 0, all counters 0.
- A button press seen at edge N produces the buffer update or state change visible after edge N+1. The latency is 1 cycle from the registered edge.
- set_time is high for exactly 1 cycle, 1 cycle after the E_SEC mode press is registered. bin_time is stable from that cycle until the next edit.
- bin_time tracks the buffer continuously. Consumers qualify it with set_time only.
- Reset asserted mid-edit discards the buffer immediately (asynchronously) and does not produce set_time.
- Once the COMMIT state is entered it always completes. A cancel press in the COMMIT cycle is ignored.

## Configuration
- Macro WATCH_SET_AUTOREPEAT_EN.
- Defined:
  - While up or down is held alone in an edit state, a hold counter runs.
  - At HOLD_CYC it generates one step, then one further step every RPT_CYC cycles until release.
  - Releasing the button, pressing another button, or a state change clears the counter.
- Undefined: only rising edges step. The hold logic and counters are removed, and the HOLD_CYC and RPT_CYC parameters are unused.

## Test plan
- cur_time={8'd21,8'd3,8'd15,8'd10,8'd30,8'd0}. Press mode 7 times with no edits -> exactly one set_time pulse, bin_time equal to the snapshot, then editing=0.
- Enter edit, go to E_MON with month=1, press down -> month=12. Go to E_HOUR with hour=23, press up -> hour=0.
- Snapshot day=31, month=1. Go to E_MON and press up -> month=2, day=28 in the same cycle.
- Press up at E_MIN, then cancel -> state IDLE, field_sel=0, set_time never asserted.
- Run with TIMEOUT_CYC=100 and no presses after entering edit -> IDLE after 100 cycles with no set_time. Repeat with a press at cycle 90 -> still editing at cycle 150.
- With WATCH_SET_AUTOREPEAT_EN, HOLD_CYC=10, RPT_CYC=4: hold up for 30 cycles on E_SEC starting from 0 -> second=6 (1 edge step plus repeats at 10, 14, 18, 22, 26).

Source files
------------

// File: rtl/watch_set_ctrl.sv
// Button-driven time-setting controller: snapshots the running time, edits it field by field, then strobes a load.
// Define WATCH_SET_AUTOREPEAT_EN to enable hold-to-repeat stepping of up/down.
module watch_set_ctrl #(
  parameter logic [31:0] HOLD_CYC    = 32'd50_000_000,
  parameter logic [31:0] RPT_CYC     = 32'd10_000_000,
  parameter logic [31:0] TIMEOUT_CYC = 32'd500_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [47:0] cur_time,
  input  logic        btn_mode,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_cancel,
  output logic        set_time,
  output logic [47:0] bin_time,
  output logic        editing,
  output logic [2:0]  field_sel
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    E_YEAR = 3'd1,
    E_MON  = 3'd2,
    E_DAY  = 3'd3,
    E_HOUR = 3'd4,
    E_MIN  = 3'd5,
    E_SEC  = 3'd6,
    COMMIT = 3'd7
  } state_t;

  localparam int BTN_MODE   = 0;
  localparam int BTN_UP     = 1;
  localparam int BTN_DOWN   = 2;
  localparam int BTN_CANCEL = 3;

  state_t      state_reg, state_next;
  logic [47:0] buf_reg, buf_next;
  logic [31:0] to_cnt_reg, to_cnt_next;
  logic [3:0]  btn_lvl, lvl_prev_reg, press_reg;
  logic        in_edit, any_press, timeout_hit;
  logic        step_up, step_dn, rpt_up, rpt_dn;
  logic [7:0]  mon_stepped;

  function automatic logic [7:0] max_day(input logic [7:0] month);
    case (month)
      8'd2:                    return 8'd28;
      8'd4, 8'd6, 8'd9, 8'd11: return 8'd30;
      default:                 return 8'd31;
    endcase
  endfunction

  // Out-of-range values snap to the minimum regardless of direction.
  function automatic logic [7:0] step_field(input logic [7:0] v, input logic [7:0] lo,
                                            input logic [7:0] hi, input logic up);
    if (v < lo || v > hi) return lo;
    if (up) return (v == hi) ? lo : v + 8'd1;
    return (v == lo) ? hi : v - 8'd1;
  endfunction

  if (HOLD_CYC == 32'd0 || RPT_CYC == 32'd0) begin : g_bad_repeat_cfg
    $error("HOLD_CYC and RPT_CYC must be nonzero");
  end

  assign btn_lvl = {btn_cancel, btn_down, btn_up, btn_mode};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lvl_prev_reg <= 4'b0;
      press_reg    <= 4'b0;
    end else begin
      lvl_prev_reg <= btn_lvl;
      press_reg    <= btn_lvl & ~lvl_prev_reg;
    end
  end

  assign in_edit   = (state_reg inside {E_YEAR, E_MON, E_DAY, E_HOUR, E_MIN, E_SEC});
  assign any_press = |press_reg;
  assign timeout_hit = (TIMEOUT_CYC != 32'd0) && in_edit && !any_press &&
                       (to_cnt_reg == TIMEOUT_CYC - 32'd1);
  assign to_cnt_next = (in_edit && !any_press && !timeout_hit) ? to_cnt_reg + 32'd1 : 32'd0;

`ifdef WATCH_SET_AUTOREPEAT_EN
  logic [31:0] hold_cnt_reg, rpt_cnt_reg;
  logic        hold_active, rpt_fire;

  // Exactly one of up/down held, nothing else held, and the state is not about to move.
  assign hold_active = in_edit && (lvl_prev_reg[BTN_UP] ^ lvl_prev_reg[BTN_DOWN]) &&
                       !lvl_prev_reg[BTN_MODE] && !lvl_prev_reg[BTN_CANCEL] &&
                       (state_next == state_reg);
  assign rpt_fire = hold_active && (hold_cnt_reg == HOLD_CYC) && (rpt_cnt_reg == 32'd0);
  assign rpt_up   = rpt_fire & lvl_prev_reg[BTN_UP];
  assign rpt_dn   = rpt_fire & lvl_prev_reg[BTN_DOWN];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_cnt_reg <= 32'd0;
      rpt_cnt_reg  <= 32'd0;
    end else if (!hold_active) begin
      hold_cnt_reg <= 32'd0;
      rpt_cnt_reg  <= 32'd0;
    end else if (hold_cnt_reg != HOLD_CYC) begin
      hold_cnt_reg <= hold_cnt_reg + 32'd1;
    end else begin
      rpt_cnt_reg <= (rpt_cnt_reg == RPT_CYC - 32'd1) ? 32'd0 : rpt_cnt_reg + 32'd1;
    end
  end
`else
  assign rpt_up = 1'b0;
  assign rpt_dn = 1'b0;
`endif

  assign step_up = (press_reg[BTN_UP] & ~press_reg[BTN_DOWN]) | rpt_up;
  assign step_dn = (press_reg[BTN_DOWN] & ~press_reg[BTN_UP]) | rpt_dn;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= IDLE;
      buf_reg    <= 48'd0;
      to_cnt_reg <= 32'd0;
    end else begin
      state_reg  <= state_next;
      buf_reg    <= buf_next;
      to_cnt_reg <= to_cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (press_reg[BTN_MODE]) state_next = E_YEAR;
      end
      COMMIT: state_next = IDLE;
      default: begin
        if (press_reg[BTN_CANCEL] || timeout_hit) begin
          state_next = IDLE;
        end else if (press_reg[BTN_MODE]) begin
          state_next = (state_reg == E_SEC) ? COMMIT : state_t'(state_reg + 3'd1);
        end
      end
    endcase
  end

  always_comb begin
    buf_next    = buf_reg;
    mon_stepped = step_field(buf_reg[39:32], 8'd1, 8'd12, step_up);
    if (state_reg == IDLE) begin
      if (press_reg[BTN_MODE]) buf_next = cur_time;
    end else if (in_edit && !press_reg[BTN_CANCEL] && !press_reg[BTN_MODE] &&
                 !timeout_hit && (step_up ^ step_dn)) begin
      case (state_reg)
        E_YEAR: buf_next[47:40] = step_field(buf_reg[47:40], 8'd0, 8'd255, step_up);
        E_MON: begin
          // Day follows the new month's length in the same cycle.
          buf_next[39:32] = mon_stepped;
          if (buf_reg[31:24] > max_day(mon_stepped)) buf_next[31:24] = max_day(mon_stepped);
        end
        E_DAY:  buf_next[31:24] = step_field(buf_reg[31:24], 8'd1, max_day(buf_reg[39:32]), step_up);
        E_HOUR: buf_next[23:16] = step_field(buf_reg[23:16], 8'd0, 8'd23, step_up);
        E_MIN:  buf_next[15:8]  = step_field(buf_reg[15:8],  8'd0, 8'd59, step_up);
        E_SEC:  buf_next[7:0]   = step_field(buf_reg[7:0],   8'd0, 8'd59, step_up);
        default: ;
      endcase
    end
  end

  always_comb begin
    set_time  = (state_reg == COMMIT);
    editing   = in_edit;
    field_sel = in_edit ? 3'(state_reg) : 3'd0;
    bin_time  = buf_reg;
  end

endmodule

// File: tb/tb_watch_set_ctrl.sv
// Randomized bench for watch_set_ctrl against a field-array reference model, plus directed boundary cases.
module tb_watch_set_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [47:0] cur_time;
  logic        btn_mode, btn_up, btn_down, btn_cancel;
  logic        set_time;
  logic [47:0] bin_time;
  logic        editing;
  logic [2:0]  field_sel;

  watch_set_ctrl #(
    .HOLD_CYC   (32'd10),
    .RPT_CYC    (32'd4),
    .TIMEOUT_CYC(32'd100)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cur_time  (cur_time),
    .btn_mode  (btn_mode),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .btn_cancel(btn_cancel),
    .set_time  (set_time),
    .bin_time  (bin_time),
    .editing   (editing),
    .field_sel (field_sel)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          set_pulses = 0;
  logic [47:0] last_commit = 48'd0;

  always @(posedge clk) begin
    if (set_time) begin
      set_pulses  <= set_pulses + 1;
      last_commit <= bin_time;
    end
  end

  // Reference model: mstate 0 = idle, 1..6 = editing field mstate-1 (year..second).
  int          mfld[6];
  int          mstate;
  int          exp_pulses;
  logic [47:0] exp_commit;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int mday(input int m);
    if (m == 2) return 28;
    if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
    return 31;
  endfunction

  function automatic int fmin(input int f);
    return (f == 1 || f == 2) ? 1 : 0;
  endfunction

  function automatic int fmax(input int f);
    case (f)
      0: return 255;
      1: return 12;
      2: return mday(mfld[1]);
      3: return 23;
      default: return 59;
    endcase
  endfunction

  function automatic logic [47:0] mpack();
    logic [47:0] p;
    p = 48'd0;
    for (int i = 0; i < 6; i++) p[47-8*i -: 8] = mfld[i][7:0];
    return p;
  endfunction

  task automatic mstep(input int f, input bit up);
    int lo = fmin(f);
    int hi = fmax(f);
    int v  = mfld[f];
    if (v < lo || v > hi) v = lo;
    else if (up) v = (v == hi) ? lo : v + 1;
    else v = (v == lo) ? hi : v - 1;
    mfld[f] = v;
    if (f == 1 && mfld[2] > mday(v)) mfld[2] = mday(v);
  endtask

  task automatic model_apply(input bit m, input bit u, input bit d, input bit c,
                             input logic [47:0] snap);
    if (mstate == 0) begin
      if (m) begin
        for (int i = 0; i < 6; i++) mfld[i] = int'(snap[47-8*i -: 8]);
        mstate = 1;
      end
    end else if (c) begin
      mstate = 0;
    end else if (m) begin
      if (mstate == 6) begin
        exp_pulses++;
        exp_commit = mpack();
        mstate = 0;
      end else begin
        mstate++;
      end
    end else if (u ^ d) begin
      mstep(mstate - 1, u);
    end
  endtask

  task automatic press(input bit m, input bit u, input bit d, input bit c);
    @(negedge clk);
    btn_mode = m; btn_up = u; btn_down = d; btn_cancel = c;
    model_apply(m, u, d, c, cur_time);
    @(negedge clk);
    btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0; btn_cancel = 1'b0;
    repeat (3) @(negedge clk);
    $display("t=%0t btn m%0b u%0b d%0b c%0b -> field_sel=%0d bin_time=%h", $time, m, u, d, c,
             field_sel, bin_time);
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".editing"},   64'(editing),   64'(mstate != 0));
    check({tag, ".field_sel"}, 64'(field_sel), 64'(mstate));
    check({tag, ".bin_time"},  64'(bin_time),  64'(mpack()));
    check({tag, ".pulses"},    64'(set_pulses), 64'(exp_pulses));
    check({tag, ".commit"},    64'(last_commit), 64'(exp_commit));
  endtask

  initial begin
    int r;
    rst = 1'b0;
    btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0; btn_cancel = 1'b0;
    cur_time = 48'd0;
    mstate = 0; exp_pulses = 0; exp_commit = 48'd0;
    for (int i = 0; i < 6; i++) mfld[i] = 0;

    repeat (3) @(negedge clk);
    check_outputs("reset");
    check("reset.set_time", 64'(set_time), 64'd0);
    rst = 1'b1;
    @(negedge clk);

    // Seven mode presses with no edits commit the snapshot unchanged.
    cur_time = {8'd21, 8'd3, 8'd15, 8'd10, 8'd30, 8'd0};
    for (int i = 0; i < 7; i++) press(1, 0, 0, 0);
    check_outputs("plain_commit");
    check("plain_commit.word", 64'(last_commit), 64'h15030F0A1E00);
    check("plain_commit.count", 64'(set_pulses), 64'd1);

    // Month 1 down wraps to 12; hour 23 up wraps to 0.
    cur_time = {8'd21, 8'd1, 8'd15, 8'd23, 8'd30, 8'd0};
    press(1, 0, 0, 0); press(1, 0, 0, 0); press(0, 0, 1, 0);
    check("mon_wrap", 64'(bin_time[39:32]), 64'd12);
    press(1, 0, 0, 0); press(1, 0, 0, 0); press(0, 1, 0, 0);
    check("hour_wrap", 64'(bin_time[23:16]), 64'd0);
    check_outputs("wraps");
    press(0, 0, 0, 1);

    // Jan 31 -> Feb clamps the day in the same step.
    cur_time = {8'd21, 8'd1, 8'd31, 8'd5, 8'd5, 8'd5};
    press(1, 0, 0, 0); press(1, 0, 0, 0); press(0, 1, 0, 0);
    check("clamp.month", 64'(bin_time[39:32]), 64'd2);
    check("clamp.day", 64'(bin_time[31:24]), 64'd28);
    press(0, 0, 0, 1);

    // Out-of-range snapshot fields normalise to their minimum on the first step.
    cur_time = {8'd7, 8'd0, 8'd10, 8'd30, 8'd0, 8'd0};
    press(1, 0, 0, 0); press(1, 0, 0, 0); press(0, 1, 0, 0);
    check("norm.month", 64'(bin_time[39:32]), 64'd1);
    press(1, 0, 0, 0); press(1, 0, 0, 0); press(0, 0, 1, 0);
    check("norm.hour", 64'(bin_time[23:16]), 64'd0);
    press(0, 0, 0, 1);

    // Edit minute then cancel: no load strobe.
    r = set_pulses;
    cur_time = {8'd21, 8'd3, 8'd15, 8'd10, 8'd30, 8'd0};
    for (int i = 0; i < 5; i++) press(1, 0, 0, 0);
    press(0, 1, 0, 0);
    press(0, 0, 0, 1);
    check("cancel.field_sel", 64'(field_sel), 64'd0);
    check("cancel.pulses", 64'(set_pulses), 64'(r));
    check_outputs("cancel");

    // Cancel landing in the commit cycle is ignored.
    for (int i = 0; i < 6; i++) press(1, 0, 0, 0);
    @(negedge clk); btn_mode = 1'b1;
    model_apply(1, 0, 0, 0, cur_time);
    @(negedge clk); btn_mode = 1'b0; btn_cancel = 1'b1;
    @(negedge clk); btn_cancel = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs("commit_cancel");

    // Timeout with no activity: still editing 99 cycles in, idle at 100.
    r = set_pulses;
    press(1, 0, 0, 0);
    repeat (97) @(negedge clk);
    check("timeout.before", 64'(editing), 64'd1);
    @(negedge clk);
    check("timeout.after", 64'(editing), 64'd0);
    check("timeout.pulses", 64'(set_pulses), 64'(r));
    mstate = 0;
    check_outputs("timeout");

    // A press near cycle 90 restarts the timeout.
    press(1, 0, 0, 0);
    repeat (86) @(negedge clk);
    press(0, 1, 0, 0);
    repeat (57) @(negedge clk);
    check("timeout_rearm.c150", 64'(editing), 64'd1);
    repeat (60) @(negedge clk);
    check("timeout_rearm.late", 64'(editing), 64'd0);
    mstate = 0;
    check_outputs("timeout_rearm");

    // Asynchronous reset mid-edit clears the buffer without a clock edge.
    press(1, 0, 0, 0); press(0, 1, 0, 0);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("async_rst.bin_time", 64'(bin_time), 64'd0);
    check("async_rst.editing", 64'(editing), 64'd0);
    check("async_rst.set_time", 64'(set_time), 64'd0);
    mstate = 0;
    for (int i = 0; i < 6; i++) mfld[i] = 0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    check_outputs("post_rst");

`ifdef WATCH_SET_AUTOREPEAT_EN
    // Hold up on seconds for 30 cycles: one edge step plus five repeats.
    cur_time = {8'd21, 8'd3, 8'd15, 8'd10, 8'd30, 8'd0};
    for (int i = 0; i < 6; i++) press(1, 0, 0, 0);
    @(negedge clk); btn_up = 1'b1;
    repeat (30) @(negedge clk);
    btn_up = 1'b0;
    repeat (4) @(negedge clk);
    check("autorepeat.sec", 64'(bin_time[7:0]), 64'd6);
    mfld[5] = 6;
    check_outputs("autorepeat");
    press(0, 0, 0, 1);
`endif

    for (int k = 0; k < 200; k++) begin
      cur_time = {8'($urandom_range(0, 255)), 8'($urandom_range(1, 12)), 8'($urandom_range(0, 35)),
                  8'($urandom_range(0, 26)), 8'($urandom_range(0, 63)), 8'($urandom_range(0, 63))};
      r = int'($urandom_range(0, 99));
      if (mstate == 0) begin
        if (r < 70)      press(1, 0, 0, 0);
        else if (r < 80) press(0, 1, 0, 0);
        else if (r < 90) press(0, 0, 1, 0);
        else             press(0, 0, 0, 1);
      end else begin
        if (r < 22)      press(1, 0, 0, 0);
        else if (r < 50) press(0, 1, 0, 0);
        else if (r < 78) press(0, 0, 1, 0);
        else if (r < 83) press(0, 0, 0, 1);
        else if (r < 89) press(0, 1, 1, 0);
        else if (r < 94) press(1, 1, 0, 0);
        else             press(1, 0, 0, 1);
      end
      check_outputs($sformatf("rnd%0d", k));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
